// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result handshake between execute stage and the M unit.
// master drives requests and takes results; slave is the unit itself.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 5
);
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [CONTROL_WIDTH-1:0] mdu_control_i;
  logic [DATA_WIDTH-1:0]    src_1_i;
  logic [DATA_WIDTH-1:0]    src_2_i;
  logic [DATA_WIDTH-1:0]    result_o;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic                     busy_o;

  modport master (
    output flush_i,
    output valid_i,
    output mdu_control_i,
    output src_1_i,
    output src_2_i,
    output result_ready_i,
    input  ready_o,
    input  result_o,
    input  result_valid_o,
    input  busy_o
  );

  modport slave (
    input  flush_i,
    input  valid_i,
    input  mdu_control_i,
    input  src_1_i,
    input  src_2_i,
    input  result_ready_i,
    output ready_o,
    output result_o,
    output result_valid_o,
    output busy_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide beside the execute-stage ALU.
// One product or quotient bit per cycle; div-by-zero and overflow bypass the loop.
module mul_div_unit #(
  parameter int DATA_WIDTH    = 64,
  parameter int WORD_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 5
) (
  input logic           clk_i,
  input logic           rst_i,
  mul_div_unit_if.slave bus
);
  localparam int DW    = DATA_WIDTH;
  localparam int WW    = WORD_WIDTH;
  localparam int CW    = CONTROL_WIDTH;
  localparam int CNT_W = $clog2(DW);

  localparam logic [CW-1:0] OP_MUL    = CW'(5'b01111);
  localparam logic [CW-1:0] OP_MULH   = CW'(5'b10000);
  localparam logic [CW-1:0] OP_MULHSU = CW'(5'b10001);
  localparam logic [CW-1:0] OP_MULHU  = CW'(5'b10010);
  localparam logic [CW-1:0] OP_DIV    = CW'(5'b10011);
  localparam logic [CW-1:0] OP_DIVU   = CW'(5'b10100);
  localparam logic [CW-1:0] OP_REM    = CW'(5'b10101);
  localparam logic [CW-1:0] OP_REMU   = CW'(5'b10110);
  localparam logic [CW-1:0] OP_MULW   = CW'(5'b10111);
  localparam logic [CW-1:0] OP_DIVW   = CW'(5'b11000);
  localparam logic [CW-1:0] OP_DIVUW  = CW'(5'b11001);
  localparam logic [CW-1:0] OP_REMW   = CW'(5'b11010);
  localparam logic [CW-1:0] OP_REMUW  = CW'(5'b11011);

  localparam logic [DW-1:0] MIN_D = {1'b1, {(DW-1){1'b0}}};
  localparam logic [WW-1:0] MIN_W = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;
  logic [DW-1:0]    result_q;
  logic [CNT_W-1:0] counter;
  logic [CW-1:0]    op_q;
  logic             mul_q;
  logic             w_q;
  logic             neg_q;
  logic             neg_r;
  logic [2*DW-1:0]  mcand;
  logic [2*DW-1:0]  acc;
  logic [DW-1:0]    mplier;

  function automatic logic [DW-1:0] sx(input logic [WW-1:0] x);
    return {{(DW-WW){x[WW-1]}}, x};
  endfunction

  logic c_legal;
  logic c_mul;
  logic c_w;
  logic c_sa;
  logic c_sb;
  logic c_rem;

  always_comb begin
    c_legal = 1'b1;
    c_mul   = 1'b0;
    c_w     = 1'b0;
    c_sa    = 1'b0;
    c_sb    = 1'b0;
    c_rem   = 1'b0;
    unique case (bus.mdu_control_i)
      OP_MUL:    {c_mul, c_sa, c_sb} = 3'b111;
      OP_MULH:   {c_mul, c_sa, c_sb} = 3'b111;
      OP_MULHSU: {c_mul, c_sa} = 2'b11;
      OP_MULHU:  c_mul = 1'b1;
      OP_DIV:    {c_sa, c_sb} = 2'b11;
      OP_DIVU:   c_rem = 1'b0;
      OP_REM:    {c_rem, c_sa, c_sb} = 3'b111;
      OP_REMU:   c_rem = 1'b1;
      OP_MULW:   {c_mul, c_w, c_sa, c_sb} = 4'b1111;
      OP_DIVW:   {c_w, c_sa, c_sb} = 3'b111;
      OP_DIVUW:  c_w = 1'b1;
      OP_REMW:   {c_rem, c_w, c_sa, c_sb} = 4'b1111;
      OP_REMUW:  {c_rem, c_w} = 2'b11;
      default:   c_legal = 1'b0;
    endcase
  end

  logic [DW-1:0] src_1;
  logic [DW-1:0] src_2;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] mag_a;
  logic [DW-1:0] mag_b;
  logic [DW-1:0] dvd_ext;
  logic [DW-1:0] spec_res;
  logic          neg_a;
  logic          neg_b;
  logic          div_zero;
  logic          div_ovf;
  logic          special;
  logic          accept;

  assign src_1 = bus.src_1_i;
  assign src_2 = bus.src_2_i;

  // *W operands are narrowed first so magnitudes fit the low WW bits
  assign op_a = c_w ? {{(DW-WW){c_sa & src_1[WW-1]}}, src_1[WW-1:0]} : src_1;
  assign op_b = c_w ? {{(DW-WW){c_sb & src_2[WW-1]}}, src_2[WW-1:0]} : src_2;

  assign neg_a = c_sa & op_a[DW-1];
  assign neg_b = c_sb & op_b[DW-1];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;

  assign div_zero = !c_mul &&
                    (c_w ? (src_2[WW-1:0] == '0) : (src_2 == '0));
  assign div_ovf  = !c_mul && c_sa &&
                    (c_w ? (src_1[WW-1:0] == MIN_W && src_2[WW-1:0] == '1)
                         : (src_1 == MIN_D && src_2 == '1));
  assign special  = div_zero | div_ovf;

  assign dvd_ext  = c_w ? sx(src_1[WW-1:0]) : src_1;
  assign spec_res = c_rem ? (div_ovf ? '0 : dvd_ext)
                          : (div_zero ? '1 : dvd_ext);

  assign accept = (state == IDLE) && bus.valid_i && c_legal;

  logic [2*DW-1:0]  mul_acc;
  logic [2*DW-1:0]  prod_s;
  logic [DW:0]      r_sh;
  logic [DW:0]      r_diff;
  logic             ge;
  logic [DW-1:0]    rem_nx;
  logic [DW-1:0]    quo_nx;
  logic [DW-1:0]    q_s;
  logic [DW-1:0]    r_s;
  logic [DW-1:0]    final_res;
  logic [CNT_W-1:0] last;

  assign mul_acc = mplier[0] ? acc + mcand : acc;

  // borrow out of the trial subtract means the partial remainder was smaller
  assign r_sh   = {acc[DW-1:0], mplier[DW-1]};
  assign r_diff = r_sh - {1'b0, mcand[DW-1:0]};
  assign ge     = ~r_diff[DW];
  assign rem_nx = ge ? r_diff[DW-1:0] : r_sh[DW-1:0];
  assign quo_nx = {mplier[DW-2:0], ge};

  assign prod_s = neg_q ? -mul_acc : mul_acc;
  assign q_s    = neg_q ? -quo_nx : quo_nx;
  assign r_s    = neg_r ? -rem_nx : rem_nx;
  assign last   = w_q ? CNT_W'(WW-1) : CNT_W'(DW-1);

  always_comb begin
    final_res = result_q;
    unique case (op_q)
      OP_MUL:    final_res = prod_s[DW-1:0];
      OP_MULH:   final_res = prod_s[2*DW-1:DW];
      OP_MULHSU: final_res = prod_s[2*DW-1:DW];
      OP_MULHU:  final_res = prod_s[2*DW-1:DW];
      OP_MULW:   final_res = sx(prod_s[WW-1:0]);
      OP_DIV:    final_res = q_s;
      OP_DIVU:   final_res = q_s;
      OP_REM:    final_res = r_s;
      OP_REMU:   final_res = r_s;
      OP_DIVW:   final_res = sx(q_s[WW-1:0]);
      OP_DIVUW:  final_res = sx(q_s[WW-1:0]);
      OP_REMW:   final_res = sx(r_s[WW-1:0]);
      OP_REMUW:  final_res = sx(r_s[WW-1:0]);
      default:   final_res = result_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      counter  <= '0;
      op_q     <= '0;
      mul_q    <= 1'b0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
    end else if (bus.flush_i) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      counter <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.mdu_control_i;
            mul_q   <= c_mul;
            w_q     <= c_w;
            neg_q   <= neg_a ^ neg_b;
            neg_r   <= neg_a;
            counter <= '0;
            acc     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (c_mul) begin
              mcand  <= {{DW{1'b0}}, mag_a};
              mplier <= mag_b;
            end else begin
              mcand  <= {{DW{1'b0}}, mag_b};
              mplier <= c_w ? {mag_a[WW-1:0], {(DW-WW){1'b0}}} : mag_a;
            end
            if (special) begin
              state    <= DONE;
              result_q <= spec_res;
              valid_q  <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (mul_q) begin
            acc    <= mul_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            acc    <= {{DW{1'b0}}, rem_nx};
            mplier <= quo_nx;
          end
          if (counter == last) begin
            state    <= DONE;
            result_q <= final_res;
            valid_q  <= 1'b1;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          if (bus.result_ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o        = ready_q;
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = valid_q;
  assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random RV64M ops against an arithmetic reference.
// Checks results, latency, DONE hold, flush and reset behaviour.
module tb_mul_div_unit;
  localparam logic [4:0] MUL    = 5'b01111;
  localparam logic [4:0] MULH   = 5'b10000;
  localparam logic [4:0] MULHSU = 5'b10001;
  localparam logic [4:0] MULHU  = 5'b10010;
  localparam logic [4:0] DIV    = 5'b10011;
  localparam logic [4:0] DIVU   = 5'b10100;
  localparam logic [4:0] REM    = 5'b10101;
  localparam logic [4:0] REMU   = 5'b10110;
  localparam logic [4:0] MULW   = 5'b10111;
  localparam logic [4:0] DIVW   = 5'b11000;
  localparam logic [4:0] DIVUW  = 5'b11001;
  localparam logic [4:0] REMW   = 5'b11010;
  localparam logic [4:0] REMUW  = 5'b11011;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] model(input logic [4:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] p;
    logic [127:0] pu;
    logic signed [63:0] sa, sb;
    logic signed [31:0] wa, wb;
    logic [31:0] ua, ub;
    sa = a; sb = b;
    wa = a[31:0]; wb = b[31:0];
    ua = a[31:0]; ub = b[31:0];
    case (op)
      MUL:    begin p = sa * sb; return p[63:0]; end
      MULH:   begin p = sa * sb; return p[127:64]; end
      MULHSU: begin p = sa * $signed({1'b0, b}); return p[127:64]; end
      MULHU:  begin pu = {64'b0, a} * {64'b0, b}; return pu[127:64]; end
      MULW:   return sx32(ua * ub);
      DIV: begin
        if (b == 0) return '1;
        if (a == MIN64 && b == '1) return a;
        return sa / sb;
      end
      REM: begin
        if (b == 0) return a;
        if (a == MIN64 && b == '1) return '0;
        return sa % sb;
      end
      DIVU: return (b == 0) ? '1 : a / b;
      REMU: return (b == 0) ? a : a % b;
      DIVW: begin
        if (wb == 0) return '1;
        if (wa == 32'sh8000_0000 && wb == -1) return sx32(ua);
        return sx32(wa / wb);
      end
      DIVUW: return (ub == 0) ? '1 : sx32(ua / ub);
      REMW: begin
        if (wb == 0) return sx32(ua);
        if (wa == 32'sh8000_0000 && wb == -1) return '0;
        return sx32(wa % wb);
      end
      REMUW: return (ub == 0) ? sx32(ua) : sx32(ua % ub);
      default: return '0;
    endcase
  endfunction

  function automatic int lat_model(input logic [4:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    bit w, dv, sgn, zero, ovf;
    w    = op inside {MULW, DIVW, DIVUW, REMW, REMUW};
    dv   = op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
    sgn  = op inside {DIV, REM, DIVW, REMW};
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                     : (a == MIN64 && b == '1));
    if (dv && (zero || ovf)) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    longint v;
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return MIN64;
      4: return 64'h0000_0000_8000_0000;
      5: begin
        v = longint'($urandom_range(0, 20)) - 10;
        return 64'(v);
      end
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [4:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat,
                       input int hold);
    int lat;
    check({tag, "_ready_pre"}, 64'(bus.ready_o), 64'd1);
    bus.mdu_control_i = op;
    bus.src_1_i = a;
    bus.src_2_i = b;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.src_1_i = {$urandom, $urandom};
    bus.src_2_i = {$urandom, $urandom};
    lat = 1;
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
    while (!bus.result_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, bus.result_o, exp);
    for (int i = 0; i < hold; i++) begin
      bus.valid_i = 1'b1;
      bus.mdu_control_i = MUL;
      @(posedge clk); #1;
      check({tag, "_hold_result"}, bus.result_o, exp);
      check({tag, "_hold_valid"}, 64'(bus.result_valid_o), 64'd1);
      check({tag, "_hold_ready"}, 64'(bus.ready_o), 64'd0);
    end
    bus.result_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.result_ready_i = 1'b0;
    bus.valid_i = 1'b0;
    check({tag, "_valid_post"}, 64'(bus.result_valid_o), 64'd0);
    check({tag, "_ready_post"}, 64'(bus.ready_o), 64'd1);
    check({tag, "_busy_post"}, 64'(bus.busy_o), 64'd0);
  endtask

  logic [4:0] ops [13] = '{MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM,
                           REMU, MULW, DIVW, DIVUW, REMW, REMUW};
  logic [4:0] bad [4] = '{5'b00000, 5'b01110, 5'b11100, 5'b11111};

  initial begin
    int seen;
    logic [4:0] op;
    logic [63:0] a, b;

    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.mdu_control_i = '0;
    bus.src_1_i = '0;
    bus.src_2_i = '0;
    bus.result_ready_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 64'(bus.ready_o), 64'd1);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_valid", 64'(bus.result_valid_o), 64'd0);
    check("rst_result", bus.result_o, 64'd0);

    do_op("mul_7x-3", MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op("mulhu", MULHU, '1, 64'd2, 64'd1, 65, 0);
    do_op("mulh", MULH, '1, '1, 64'd0, 65, 1);
    do_op("mulhsu", MULHSU, '1, 64'd2, '1, 65, 0);
    do_op("div_hold", DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 10);
    do_op("rem", REM, -64'sd7, 64'd2, '1, 65, 0);
    do_op("divw_ovf", DIVW, 64'h0000_0000_8000_0000, '1,
          64'hFFFF_FFFF_8000_0000, 1, 0);
    do_op("divu_z", DIVU, 64'd5, 64'd0, '1, 1, 2);
    do_op("remu_z", REMU, 64'd5, 64'd0, 64'd5, 1, 0);

    foreach (bad[i]) begin
      bus.mdu_control_i = bad[i];
      bus.valid_i = 1'b1;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      check("illegal_busy", 64'(bus.busy_o), 64'd0);
      check("illegal_ready", 64'(bus.ready_o), 64'd1);
    end

    bus.mdu_control_i = MUL;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_idle_busy", 64'(bus.busy_o), 64'd0);
    check("flush_idle_ready", 64'(bus.ready_o), 64'd1);

    bus.mdu_control_i = DIV;
    bus.src_1_i = -64'sd100;
    bus.src_2_i = 64'd7;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("flush_busy_pre", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_busy", 64'(bus.busy_o), 64'd0);
    check("flush_ready", 64'(bus.ready_o), 64'd1);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.result_valid_o) seen = 1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    do_op("mulw_3x4", MULW, 64'd3, 64'd4, 64'd12, 33, 0);

    bus.mdu_control_i = MUL;
    bus.src_1_i = 64'd9;
    bus.src_2_i = 64'd9;
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 64'(bus.ready_o), 64'd1);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_valid", 64'(bus.result_valid_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);

    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 12)];
      a = pick();
      b = pick();
      do_op($sformatf("rnd%0d_op%b", n, op), op, a, b, model(op, a, b),
            lat_model(op, a, b), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
